mem_arbiter: RTL

Shares the single main-memory port between the instruction-cache miss engine (I side, read-only) and the data-cache miss/writeback engine (D side, read/write). It accepts one transaction at a time and drives one request cycle into memory. It waits for memory completion, then returns data and a done pulse to the owning requester. D side has priority because it belongs to the older instruction, but a streak counter prevents I-side starvation.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter shared by the I-cache and D-cache miss engines.
// D side wins by default; a streak counter forces an I grant after MAX_D_STREAK.
module mem_arbiter #(
    parameter int MAX_D_STREAK = 2,
    parameter int AW           = 16,
    parameter int DW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_done,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          i_done,
    output logic          d_done,
    output logic [DW-1:0] rdata,
    output logic          i_grant,
    output logic          d_grant
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic          r_mem_en;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_i_done;
    logic          r_d_done;
    logic [DW-1:0] r_rdata;
    logic          r_i_grant;
    logic          r_d_grant;

    logic w_any_req;
    logic w_i_starved;
    logic w_d_wins;

    assign w_any_req   = i_req | d_req;
    assign w_i_starved = i_req & (r_streak == STREAK_MAX);
    assign w_d_wins    = d_req & ~w_i_starved;

    // Transaction FSM: arbitrate, issue one mem_en, wait, return done/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_rdata     <= '0;
            r_i_grant   <= 1'b0;
            r_d_grant   <= 1'b0;
        end else begin
            r_mem_en <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_mem_en <= 1'b1;
                        r_state  <= S_ISSUE;
                        if (w_d_wins) begin
                            r_mem_addr  <= d_addr;
                            r_mem_wr    <= d_wr;
                            r_mem_wdata <= d_wdata;
                            r_d_grant   <= 1'b1;
                            if (!i_req) begin
                                r_streak <= '0;
                            end else if (r_streak != STREAK_MAX) begin
                                r_streak <= r_streak + 1'b1;
                            end
                        end else begin
                            r_mem_addr  <= i_addr;
                            r_mem_wr    <= 1'b0;
                            r_mem_wdata <= '0;
                            r_i_grant   <= 1'b1;
                            r_streak    <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (mem_done) begin
                        r_rdata  <= mem_rdata;
                        r_i_done <= r_i_grant;
                        r_d_done <= r_d_grant;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_i_grant <= 1'b0;
                    r_d_grant <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;
    assign rdata     = r_rdata;
    assign i_grant   = r_i_grant;
    assign d_grant   = r_d_grant;

endmodule
